// File: rtl/mat_pair_loader_if.sv
// Intake stream and output pair bus of the matrix pair loader.
// Intake: an element moves when valid_in && accept_out at a rising edge; output: a pair moves when ready_out && accept_in.
interface mat_pair_loader_if #(
    parameter int DW = 16,
    parameter int N  = 4,
    parameter int CW = 16
);
    logic              enable;
    logic              valid_in;
    logic [DW-1:0]     data_in;
    logic              accept_out;
    logic              ready_out;
    logic              accept_in;
    logic [N*N*DW-1:0] A;
    logic [N*N*DW-1:0] B;
    logic [CW-1:0]     pairs_sent;
    // Loader FSM state for observation: 0 = LOAD_A, 1 = LOAD_B, 2 = HOLD.
    logic [1:0]        fsm_state;

    modport master (
        input  enable, valid_in, data_in, accept_in,
        output accept_out, ready_out, A, B, pairs_sent, fsm_state
    );

    modport slave (
        output enable, valid_in, data_in, accept_in,
        input  accept_out, ready_out, A, B, pairs_sent, fsm_state
    );
endinterface

// File: rtl/mat_pair_loader.sv
// Assembles a serial element stream into a 4x4 A/B operand pair and hands it to the
// matrix multiplier through a double buffer (fill buffers feed the A/B output registers).
module mat_pair_loader #(
    parameter int DW = 16,
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    mat_pair_loader_if.master bus
);
    localparam int NE = N * N;
    localparam int IW = $clog2(NE);
    localparam int MW = NE * DW;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [MW-1:0]   fill_a_q, fill_a_d, fill_b_q, fill_b_d;
    logic [MW-1:0]   fill_a_wr, fill_b_wr;
    logic [MW-1:0]   a_q, a_d, b_q, b_d;
    logic            ready_q, ready_d;
    logic [CW-1:0]   sent_q, sent_d;
    logic            accept;
    logic            take;
    logic            last;
    logic            out_xfer;
    logic            load_pair;

    // accept_out is forced low during reset so no element is taken while the loader is cleared.
    assign accept   = reset_n && bus.enable && (state_q != HOLD);
    assign take     = bus.valid_in && accept;
    assign last     = (idx_q == IW'(NE - 1));
    assign out_xfer = ready_q && bus.accept_in;

    always_comb begin
        fill_a_wr = fill_a_q;
        fill_b_wr = fill_b_q;
        fill_a_wr[idx_q*DW +: DW] = bus.data_in;
        fill_b_wr[idx_q*DW +: DW] = bus.data_in;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fill_a_d  = fill_a_q;
        fill_b_d  = fill_b_q;
        load_pair = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (take) begin
                    fill_a_d = fill_a_wr;
                    if (last) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (take) begin
                    fill_b_d = fill_b_wr;
                    if (last) begin
                        idx_d = '0;
                        // The output registers are free (or being drained this edge): publish directly.
                        if (!ready_q || bus.accept_in) begin
                            load_pair = 1'b1;
                            state_d   = LOAD_A;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.accept_in) begin
                    load_pair = 1'b1;
                    state_d   = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
        endcase

        a_d = load_pair ? fill_a_d : a_q;
        b_d = load_pair ? fill_b_d : b_q;

        // A new pair keeps ready_out high even when the previous pair is handed off on the same edge.
        ready_d = ready_q;
        if (load_pair) begin
            ready_d = 1'b1;
        end else if (out_xfer) begin
            ready_d = 1'b0;
        end

        sent_d = out_xfer ? sent_q + 1'b1 : sent_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOAD_A;
            idx_q    <= '0;
            fill_a_q <= '0;
            fill_b_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ready_q  <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fill_a_q <= fill_a_d;
            fill_b_q <= fill_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ready_q  <= ready_d;
            sent_q   <= sent_d;
        end
    end

    assign bus.accept_out = accept;
    assign bus.ready_out  = ready_q;
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.pairs_sent = sent_q;
    assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_mat_pair_loader.sv
// Directed bench for mat_pair_loader: element-count model of the pair stream checked every cycle,
// plus literal checks on the scenarios of interest.
module tb_mat_pair_loader;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int NE = N * N;
    localparam int MW = NE * DW;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    bit   check_on = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mat_pair_loader_if #(.DW(DW), .N(N), .CW(CW)) bus ();

    mat_pair_loader #(.DW(DW), .N(N), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- model: counts accepted elements, a pair completes every 2*NE ----------------
    logic [DW-1:0] m_elems [2*NE];
    logic [DW-1:0] m_out_a [NE];
    logic [DW-1:0] m_out_b [NE];
    int            m_cnt;
    bit            m_ready;
    bit            m_hold;
    logic [CW-1:0] m_sent;
    bit            m_xfer;
    bit            m_deliver;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt   = 0;
            m_ready = 1'b0;
            m_hold  = 1'b0;
            m_sent  = '0;
            for (int i = 0; i < NE; i++) begin
                m_out_a[i] = '0;
                m_out_b[i] = '0;
            end
        end else begin
            m_xfer    = m_ready && bus.accept_in;
            m_deliver = 1'b0;
            if (bus.valid_in && bus.enable && !m_hold) begin
                m_elems[m_cnt] = bus.data_in;
                m_cnt++;
                if (m_cnt == 2 * NE) begin
                    m_cnt = 0;
                    if (!m_ready || bus.accept_in) m_deliver = 1'b1;
                    else m_hold = 1'b1;
                end
            end else if (m_hold && bus.accept_in) begin
                m_deliver = 1'b1;
                m_hold    = 1'b0;
            end
            if (m_deliver) begin
                for (int i = 0; i < NE; i++) begin
                    m_out_a[i] = m_elems[i];
                    m_out_b[i] = m_elems[NE + i];
                end
                m_ready = 1'b1;
            end
            if (m_xfer) begin
                m_sent = m_sent + 1'b1;
                if (!m_deliver) m_ready = 1'b0;
            end
        end
    end

    function automatic logic [MW-1:0] pack_model(input bit sel_b);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < NE; i++) v[i*DW +: DW] = sel_b ? m_out_b[i] : m_out_a[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (check_on) begin
            check("cyc_accept_out", MW'(bus.accept_out), MW'(reset_n && bus.enable && !m_hold));
            check("cyc_ready_out", MW'(bus.ready_out), MW'(m_ready));
            check("cyc_pairs_sent", MW'(bus.pairs_sent), MW'(m_sent));
            check("cyc_A", bus.A, pack_model(1'b0));
            check("cyc_B", bus.B, pack_model(1'b1));
        end
    end

    // ---------------- driver ----------------
    task automatic send_elem(input logic [DW-1:0] d);
        int budget;
        budget       = 0;
        bus.data_in  = d;
        bus.valid_in = 1'b1;
        @(negedge clk);
        while (!bus.accept_out && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (!bus.accept_out) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: element %0h not accepted within 200 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_to_negedge();
        bus.valid_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.accept_in = 1'b0;
        #1 reset_n = 1'b0;
        check_on = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_accept_out", MW'(bus.accept_out), MW'(0));
        check("rst_ready_out", MW'(bus.ready_out), MW'(0));
        check("rst_A", bus.A, '0);
        check("rst_pairs", MW'(bus.pairs_sent), MW'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;

        // T1: one pair, consumer ready
        bus.accept_in = 1'b1;
        for (int k = 0; k < 32; k++) send_elem(DW'(k + 1));
        idle_to_negedge();
        check("t1_ready", MW'(bus.ready_out), MW'(1));
        check("t1_a0", MW'(bus.A[15:0]), MW'(1));
        check("t1_a15", MW'(bus.A[255:240]), MW'(16));
        check("t1_b0", MW'(bus.B[15:0]), MW'(17));
        check("t1_b15", MW'(bus.B[255:240]), MW'(32));
        @(negedge clk);
        check("t1_pairs", MW'(bus.pairs_sent), MW'(1));
        check("t1_ready_drop", MW'(bus.ready_out), MW'(0));

        // T2: consumer stalled, second pair parks in HOLD
        @(posedge clk);
        #1 bus.accept_in = 1'b0;
        for (int k = 0; k < 64; k++) send_elem(DW'(k + 1));
        idle_to_negedge();
        check("t2_state_hold", MW'(bus.fsm_state), MW'(2));
        check("t2_accept_out", MW'(bus.accept_out), MW'(0));
        check("t2_a0_stable", MW'(bus.A[15:0]), MW'(1));
        repeat (3) @(negedge clk);
        check("t2_a0_still", MW'(bus.A[15:0]), MW'(1));
        @(posedge clk);
        #1 bus.accept_in = 1'b1;
        @(posedge clk);
        #1 bus.accept_in = 1'b0;
        @(negedge clk);
        check("t2_a0_new", MW'(bus.A[15:0]), MW'(33));
        check("t2_ready", MW'(bus.ready_out), MW'(1));
        check("t2_accept_back", MW'(bus.accept_out), MW'(1));
        check("t2_pairs", MW'(bus.pairs_sent), MW'(2));

        // T3: final element and handshake on the same edge
        @(posedge clk);
        #1;
        for (int k = 0; k < 31; k++) send_elem(DW'(101 + k));
        bus.accept_in = 1'b1;
        send_elem(DW'(132));
        idle_to_negedge();
        check("t3_ready", MW'(bus.ready_out), MW'(1));
        check("t3_a0", MW'(bus.A[15:0]), MW'(101));
        check("t3_b15", MW'(bus.B[255:240]), MW'(132));
        check("t3_pairs", MW'(bus.pairs_sent), MW'(3));
        @(negedge clk);
        check("t3_drain", MW'(bus.pairs_sent), MW'(4));

        // T4: enable dropped mid-matrix
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) send_elem(DW'(201 + k));
        bus.enable   = 1'b0;
        bus.data_in  = DW'(211);
        bus.valid_in = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t4_accept_off", MW'(bus.accept_out), MW'(0));
        end
        @(posedge clk);
        #1 bus.enable = 1'b1;
        for (int k = 10; k < 32; k++) send_elem(DW'(201 + k));
        idle_to_negedge();
        check("t4_a0", MW'(bus.A[15:0]), MW'(201));
        check("t4_slot10", MW'(bus.A[175:160]), MW'(211));
        check("t4_b15", MW'(bus.B[255:240]), MW'(232));

        // T5: reset mid-load discards the partial pair
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) send_elem(DW'(301 + k));
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_rst_accept", MW'(bus.accept_out), MW'(0));
        check("t5_rst_ready", MW'(bus.ready_out), MW'(0));
        check("t5_rst_A", bus.A, '0);
        check("t5_rst_pairs", MW'(bus.pairs_sent), MW'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 32; k++) send_elem(DW'(401 + k));
        idle_to_negedge();
        check("t5_a0", MW'(bus.A[15:0]), MW'(401));
        check("t5_a15", MW'(bus.A[255:240]), MW'(416));
        check("t5_b15", MW'(bus.B[255:240]), MW'(432));

        // T6: extreme signed values pass through unmodified
        @(posedge clk);
        #1;
        send_elem(16'h8000);
        for (int k = 1; k < 15; k++) send_elem(DW'(k));
        send_elem(16'h7FFF);
        for (int k = 0; k < 16; k++) send_elem(DW'(500 + k));
        idle_to_negedge();
        check("t6_a0_min", MW'(bus.A[15:0]), MW'(16'h8000));
        check("t6_a15_max", MW'(bus.A[255:240]), MW'(16'h7FFF));

        repeat (4) @(negedge clk);
        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule
